// File: rtl/pipeline_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core, with stall,
// bubble and branch-squash handling plus saturating stall/flush event counters.
module pipeline_front_regs #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall_F,
    input  logic             Stall_D,
    input  logic             Flush_E,
    input  logic             PCSrc_D,
    input  logic [WIDTH-1:0] PC_Branch_D,
    input  logic [WIDTH-1:0] Instr_F,
    output logic [WIDTH-1:0] PC_F,
    output logic [WIDTH-1:0] Instr_D,
    output logic [WIDTH-1:0] PC_Plus4_D,
    input  logic [7:0]       Ctrl_D,
    input  logic [WIDTH-1:0] RD1_D,
    input  logic [WIDTH-1:0] RD2_D,
    input  logic [WIDTH-1:0] Sign_Imm_D,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic [4:0]       Rd_D,
    output logic [7:0]       Ctrl_E,
    output logic [WIDTH-1:0] RD1_E,
    output logic [WIDTH-1:0] RD2_E,
    output logic [WIDTH-1:0] Sign_Imm_E,
    output logic [4:0]       Rs_E,
    output logic [4:0]       Rt_E,
    output logic [4:0]       Rd_E,
    output logic             Valid_E,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    logic [WIDTH-1:0] pc_reg, pc_next, pc_plus4;
    logic [WIDTH-1:0] instr_d_reg, instr_d_next;
    logic [WIDTH-1:0] pc_plus4_d_reg, pc_plus4_d_next;

    logic [7:0]       ctrl_e_reg, ctrl_e_next;
    logic [WIDTH-1:0] rd1_e_reg, rd1_e_next;
    logic [WIDTH-1:0] rd2_e_reg, rd2_e_next;
    logic [WIDTH-1:0] sign_imm_e_reg, sign_imm_e_next;
    logic [4:0]       rs_e_reg, rs_e_next;
    logic [4:0]       rt_e_reg, rt_e_next;
    logic [4:0]       rd_e_reg, rd_e_next;
    logic             valid_e_reg, valid_e_next;

    assign pc_plus4 = pc_reg + WIDTH'(4);

    // Stall outranks redirect; the branch is simply re-evaluated next cycle.
    always_comb begin
        pc_next = pc_reg;
        if (!Stall_F) begin
            pc_next = PCSrc_D ? PC_Branch_D : pc_plus4;
        end
    end

    always_comb begin
        instr_d_next    = instr_d_reg;
        pc_plus4_d_next = pc_plus4_d_reg;
        if (!Stall_D) begin
            if (PCSrc_D) begin
                instr_d_next    = '0;
                pc_plus4_d_next = '0;
            end else begin
                instr_d_next    = Instr_F;
                pc_plus4_d_next = pc_plus4;
            end
        end
    end

    // A cleared Ctrl_E has Reg_Write and Mem_Write low, so a bubble is inert.
    always_comb begin
        ctrl_e_next     = Ctrl_D;
        rd1_e_next      = RD1_D;
        rd2_e_next      = RD2_D;
        sign_imm_e_next = Sign_Imm_D;
        rs_e_next       = Rs_D;
        rt_e_next       = Rt_D;
        rd_e_next       = Rd_D;
        valid_e_next    = 1'b1;
        if (Flush_E) begin
            ctrl_e_next     = '0;
            rd1_e_next      = '0;
            rd2_e_next      = '0;
            sign_imm_e_next = '0;
            rs_e_next       = '0;
            rt_e_next       = '0;
            rd_e_next       = '0;
            valid_e_next    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= RESET_PC;
            instr_d_reg    <= '0;
            pc_plus4_d_reg <= '0;
            ctrl_e_reg     <= '0;
            rd1_e_reg      <= '0;
            rd2_e_reg      <= '0;
            sign_imm_e_reg <= '0;
            rs_e_reg       <= '0;
            rt_e_reg       <= '0;
            rd_e_reg       <= '0;
            valid_e_reg    <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            instr_d_reg    <= instr_d_next;
            pc_plus4_d_reg <= pc_plus4_d_next;
            ctrl_e_reg     <= ctrl_e_next;
            rd1_e_reg      <= rd1_e_next;
            rd2_e_reg      <= rd2_e_next;
            sign_imm_e_reg <= sign_imm_e_next;
            rs_e_reg       <= rs_e_next;
            rt_e_reg       <= rt_e_next;
            rd_e_reg       <= rd_e_next;
            valid_e_reg    <= valid_e_next;
        end
    end

    // Event 0 = stall cycle, event 1 = flush cycle (either cause counts once).
    logic [1:0]            cnt_event;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_event[0] = Stall_D;
    assign cnt_event[1] = Flush_E | (PCSrc_D & ~Stall_D);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_event[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign PC_F       = pc_reg;
    assign Instr_D    = instr_d_reg;
    assign PC_Plus4_D = pc_plus4_d_reg;
    assign Ctrl_E     = ctrl_e_reg;
    assign RD1_E      = rd1_e_reg;
    assign RD2_E      = rd2_e_reg;
    assign Sign_Imm_E = sign_imm_e_reg;
    assign Rs_E       = rs_e_reg;
    assign Rt_E       = rt_e_reg;
    assign Rd_E       = rd_e_reg;
    assign Valid_E    = valid_e_reg;
    assign Stall_Cnt  = cnt_val[0];
    assign Flush_Cnt  = cnt_val[1];

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Directed bench for pipeline_front_regs: a cycle-by-cycle vector table plus
// hand sequences for counter saturation and reset during a stall.
module tb_pipeline_front_regs;

    logic        clk;
    logic        rst;
    logic        Stall_F, Stall_D, Flush_E, PCSrc_D;
    logic [31:0] PC_Branch_D, Instr_F;
    logic [31:0] PC_F, Instr_D, PC_Plus4_D;
    logic [7:0]  Ctrl_D, Ctrl_E;
    logic [31:0] RD1_D, RD2_D, Sign_Imm_D, RD1_E, RD2_E, Sign_Imm_E;
    logic [4:0]  Rs_D, Rt_D, Rd_D, Rs_E, Rt_E, Rd_E;
    logic        Valid_E;
    logic [3:0]  Stall_Cnt, Flush_Cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_front_regs #(
        .WIDTH    (32),
        .RESET_PC (32'h0040_0000),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Stall_F     (Stall_F),
        .Stall_D     (Stall_D),
        .Flush_E     (Flush_E),
        .PCSrc_D     (PCSrc_D),
        .PC_Branch_D (PC_Branch_D),
        .Instr_F     (Instr_F),
        .PC_F        (PC_F),
        .Instr_D     (Instr_D),
        .PC_Plus4_D  (PC_Plus4_D),
        .Ctrl_D      (Ctrl_D),
        .RD1_D       (RD1_D),
        .RD2_D       (RD2_D),
        .Sign_Imm_D  (Sign_Imm_D),
        .Rs_D        (Rs_D),
        .Rt_D        (Rt_D),
        .Rd_D        (Rd_D),
        .Ctrl_E      (Ctrl_E),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Sign_Imm_E  (Sign_Imm_E),
        .Rs_E        (Rs_E),
        .Rt_E        (Rt_E),
        .Rd_E        (Rd_E),
        .Valid_E     (Valid_E),
        .Stall_Cnt   (Stall_Cnt),
        .Flush_Cnt   (Flush_Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sf, sd, fe, pcsrc;
        logic [31:0] br, instr;
        logic [7:0]  tag;
        logic [31:0] e_pc, e_instr, e_p4;
        logic        e_valid;
        logic [7:0]  e_tag;
        int          e_scnt, e_fcnt;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic sf, logic sd, logic fe, logic pcsrc,
                                logic [31:0] br, logic [31:0] instr, logic [7:0] tag,
                                logic [31:0] e_pc, logic [31:0] e_instr, logic [31:0] e_p4,
                                logic e_valid, logic [7:0] e_tag, int e_scnt, int e_fcnt);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fe = fe; v.pcsrc = pcsrc;
        v.br = br; v.instr = instr; v.tag = tag;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_p4 = e_p4;
        v.e_valid = e_valid; v.e_tag = e_tag;
        v.e_scnt = e_scnt; v.e_fcnt = e_fcnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Decode-stage operands are derived from a tag so ID/EX contents are traceable.
    task automatic drive_dec(input logic [7:0] tag);
        Ctrl_D     = tag;
        RD1_D      = 32'hA100_0000 | {24'h0, tag};
        RD2_D      = 32'hB200_0000 | {24'h0, tag};
        Sign_Imm_D = 32'hC300_0000 | {24'h0, tag};
        Rs_D       = tag[4:0];
        Rt_D       = tag[4:0] ^ 5'h1F;
        Rd_D       = tag[4:0] + 5'd1;
    endtask

    task automatic check_idex(input string pfx, input logic valid, input logic [7:0] tag);
        check({pfx, " Valid_E"},    {31'h0, Valid_E}, {31'h0, valid});
        check({pfx, " Ctrl_E"},     {24'h0, Ctrl_E},  valid ? {24'h0, tag} : 32'h0);
        check({pfx, " RD1_E"},      RD1_E,      valid ? (32'hA100_0000 | {24'h0, tag}) : 32'h0);
        check({pfx, " RD2_E"},      RD2_E,      valid ? (32'hB200_0000 | {24'h0, tag}) : 32'h0);
        check({pfx, " Sign_Imm_E"}, Sign_Imm_E, valid ? (32'hC300_0000 | {24'h0, tag}) : 32'h0);
        check({pfx, " Rs_E"}, {27'h0, Rs_E}, valid ? {27'h0, tag[4:0]} : 32'h0);
        check({pfx, " Rt_E"}, {27'h0, Rt_E}, valid ? {27'h0, tag[4:0] ^ 5'h1F} : 32'h0);
        check({pfx, " Rd_E"}, {27'h0, Rd_E}, valid ? {27'h0, tag[4:0] + 5'd1} : 32'h0);
    endtask

    task automatic check_front(input string pfx, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] p4, input int scnt, input int fcnt);
        check({pfx, " PC_F"},       PC_F,       pc);
        check({pfx, " Instr_D"},    Instr_D,    instr);
        check({pfx, " PC_Plus4_D"}, PC_Plus4_D, p4);
        check({pfx, " Stall_Cnt"},  {28'h0, Stall_Cnt}, 32'(scnt));
        check({pfx, " Flush_Cnt"},  {28'h0, Flush_Cnt}, 32'(fcnt));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            sf sd fe br  br_tgt        instr         tag    PC            Instr_D       PC+4_D      V  tag  S  F
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,        32'h1111_1111, 8'd1,  32'h0040_0004, 32'h1111_1111, 32'h0040_0004, 1, 8'd1,  0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,        32'h2222_2222, 8'd2,  32'h0040_0008, 32'h2222_2222, 32'h0040_0008, 1, 8'd2,  0, 0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h0,        32'h3333_3333, 8'd3,  32'h0000_0000, 32'h0,         32'h0,         1, 8'd3,  0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,        32'h2008_0005, 8'd4,  32'h0000_0004, 32'h2008_0005, 32'h0000_0004, 1, 8'd4,  0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,        32'h4444_4444, 8'd5,  32'h0000_0008, 32'h4444_4444, 32'h0000_0008, 1, 8'd5,  0, 1);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,        32'h5555_5555, 8'd6,  32'h0000_000C, 32'h5555_5555, 32'h0000_000C, 1, 8'd6,  0, 1);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,        32'h6666_6666, 8'd7,  32'h0000_0010, 32'h6666_6666, 32'h0000_0010, 1, 8'd7,  0, 1);
        vecs[7]  = mk(1, 1, 1, 0, 32'h0,        32'h7777_7777, 8'd8,  32'h0000_0010, 32'h6666_6666, 32'h0000_0010, 0, 8'd0,  1, 2);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,        32'h7777_7777, 8'd9,  32'h0000_0014, 32'h7777_7777, 32'h0000_0014, 1, 8'd9,  1, 2);
        vecs[9]  = mk(0, 0, 0, 1, 32'h80,       32'h8888_8888, 8'd10, 32'h0000_0080, 32'h0,         32'h0,         1, 8'd10, 1, 3);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,        32'h9999_9999, 8'd11, 32'h0000_0084, 32'h9999_9999, 32'h0000_0084, 1, 8'd11, 1, 3);
        vecs[11] = mk(1, 1, 0, 1, 32'h200,      32'hAAAA_AAAA, 8'd12, 32'h0000_0084, 32'h9999_9999, 32'h0000_0084, 1, 8'd12, 2, 3);
        vecs[12] = mk(1, 0, 0, 0, 32'h0,        32'hBBBB_BBBB, 8'd13, 32'h0000_0084, 32'hBBBB_BBBB, 32'h0000_0088, 1, 8'd13, 2, 3);
        vecs[13] = mk(0, 0, 1, 1, 32'hFFFF_FFFC, 32'hCCCC_CCCC, 8'd14, 32'hFFFF_FFFC, 32'h0,        32'h0,         0, 8'd0,  2, 4);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,        32'hDDDD_DDDD, 8'd15, 32'h0000_0000, 32'hDDDD_DDDD, 32'h0000_0000, 1, 8'd15, 2, 4);
        vecs[15] = mk(0, 1, 0, 0, 32'h0,        32'hEEEE_EEEE, 8'd16, 32'h0000_0004, 32'hDDDD_DDDD, 32'h0000_0000, 1, 8'd16, 3, 4);

        // Reset held for two edges while decode inputs carry junk.
        rst = 1'b1;
        Stall_F = 1'b0; Stall_D = 1'b0; Flush_E = 1'b0; PCSrc_D = 1'b0;
        PC_Branch_D = 32'h1234_5678; Instr_F = 32'hDEAD_BEEF;
        drive_dec(8'h5A);
        cycle();
        cycle();
        check_front("reset", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        check_idex("reset", 1'b0, 8'h0);
        $display("reset: PC_F=%h Valid_E=%0d", PC_F, Valid_E);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            Stall_F = vecs[i].sf; Stall_D = vecs[i].sd;
            Flush_E = vecs[i].fe; PCSrc_D = vecs[i].pcsrc;
            PC_Branch_D = vecs[i].br; Instr_F = vecs[i].instr;
            drive_dec(vecs[i].tag);
            cycle();
            check_front($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_p4,
                        vecs[i].e_scnt, vecs[i].e_fcnt);
            check_idex($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_tag);
            $display("vec%0d: PC_F=%h Instr_D=%h PC_Plus4_D=%h Valid_E=%0d Ctrl_E=%h Stall_Cnt=%0d Flush_Cnt=%0d",
                     i, PC_F, Instr_D, PC_Plus4_D, Valid_E, Ctrl_E, Stall_Cnt, Flush_Cnt);
        end

        // Saturation: Stall_Cnt starts at 3 and must stop at 15.
        Stall_F = 1'b1; Stall_D = 1'b1; Flush_E = 1'b0; PCSrc_D = 1'b0;
        Instr_F = 32'h0F0F_0F0F;
        drive_dec(8'd17);
        for (int i = 0; i < 20; i++) begin
            cycle();
            check($sformatf("sat%0d Stall_Cnt", i), {28'h0, Stall_Cnt},
                  32'((3 + i + 1) > 15 ? 15 : (3 + i + 1)));
            $display("sat%0d: Stall_Cnt=%0d", i, Stall_Cnt);
        end
        check_front("sat_end", 32'h0000_0004, 32'hDDDD_DDDD, 32'h0, 15, 4);
        check_idex("sat_end", 1'b1, 8'd17);

        // Reset while stall, flush and redirect are all asserted.
        rst = 1'b1;
        Flush_E = 1'b1; PCSrc_D = 1'b1; PC_Branch_D = 32'h300;
        cycle();
        check_front("rst_mid", 32'h0040_0000, 32'h0, 32'h0, 0, 0);
        check_idex("rst_mid", 1'b0, 8'h0);
        $display("rst_mid: PC_F=%h Stall_Cnt=%0d Flush_Cnt=%0d", PC_F, Stall_Cnt, Flush_Cnt);

        rst = 1'b0;
        Stall_F = 1'b0; Stall_D = 1'b0; Flush_E = 1'b0; PCSrc_D = 1'b0;
        Instr_F = 32'h0000_0020;
        drive_dec(8'd18);
        cycle();
        check("post_rst1 PC_F", PC_F, 32'h0040_0004);
        $display("post_rst1: PC_F=%h", PC_F);
        cycle();
        check("post_rst2 PC_F", PC_F, 32'h0040_0008);
        check("post_rst2 PC_Plus4_D", PC_Plus4_D, 32'h0040_0008);
        $display("post_rst2: PC_F=%h", PC_F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_front_regs.md
# pipeline_front_regs

Fetch/decode/execute pipeline register bank for the 5-stage MIPS core: the consumer of the hazard unit's Stall_F, Stall_D and Flush_E outputs. It holds the PC register, the IF/ID register and the ID/EX register. It applies stalls, bubbles and branch-redirect squashes with fixed priorities, and keeps saturating stall/flush event counters for debug. It sits between instruction memory and the decode logic and the execute stage, alongside the hazard unit.

## Interface
- WIDTH, 32, datapath width (PC, instruction, operands)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of stall/flush event counters
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  synchronous, active-high reset
- Stall_F  in  1  hold PC
- Stall_D  in  1  hold IF/ID
- Flush_E  in  1  load bubble into ID/EX
- PCSrc_D  in  1  branch taken in decode; redirect fetch and squash IF/ID
- PC_Branch_D  in  WIDTH  branch target from decode
- Instr_F  in  WIDTH  instruction read at PC_F
- PC_F  out  WIDTH  current fetch PC
- Instr_D, PC_Plus4_D  out  WIDTH  IF/ID contents
- Ctrl_D  in  8  packed decode control {Reg_Write, MemtoReg, Mem_Write, ALU_Control[2:0], ALU_Src, Reg_Dst}
- RD1_D, RD2_D, Sign_Imm_D  in  WIDTH  decode operands
- Rs_D, Rt_D, Rd_D  in  5  decode register numbers
- Ctrl_E, RD1_E, RD2_E, Sign_Imm_E, Rs_E, Rt_E, Rd_E  out  (as above)  ID/EX contents
- Valid_E  out  1  ID/EX holds a real instruction (0 = bubble)
- Stall_Cnt, Flush_Cnt  out  CNT_W  saturating event counters

## Operation
- PC register, first matching rule wins: rst -> RESET_PC; Stall_F -> hold; PCSrc_D -> PC_Branch_D; else PC_F + 4 (WIDTH-bit, wraps modulo 2^WIDTH).
- IF/ID, first matching rule wins: rst -> clear; Stall_D -> hold; PCSrc_D -> clear (Instr_D = 0 = sll $0,$0,0 nop, PC_Plus4_D = 0); else Instr_D <= Instr_F, PC_Plus4_D <= PC_F + 4.
- ID/EX, first matching rule wins: rst or Flush_E -> clear every field, Valid_E = 0; else load all _D fields, Valid_E = 1. ID/EX has no stall input.
- Bubble guarantee: a cleared Ctrl_E has Reg_Write = Mem_Write = 0, so no architectural side effects.
- Stall_Cnt increments on every cycle with Stall_D = 1.
- Flush_Cnt increments on every cycle with Flush_E = 1 or (PCSrc_D = 1 and Stall_D = 0). It counts +1 per cycle even when both causes occur together.
- Both counters saturate at 2^CNT_W - 1 and never wrap.
- Stall_F = 1 with Stall_D = 0 is accepted: the PC holds and IF/ID loads the same Instr_F again. No checking is done.

## Timing
- Every output is a register; no combinational path from any input to any output.
- Load latency for every register is 1 cycle.
- Reset values: PC_F = RESET_PC; all other outputs 0, including Valid_E, Stall_Cnt and Flush_Cnt.
- rst asserted in the middle of a stall or flush: takes effect at the next edge and overrides every other input.
- Load-use stall (Stall_F = Stall_D = Flush_E = 1 in the same cycle): PC and IF/ID hold, ID/EX gets a bubble. The stalled instruction enters EX the cycle after the stall drops.
- Taken branch (PCSrc_D = 1, no stall): at the edge, PC_F = PC_Branch_D, IF/ID = nop, and ID/EX loads the branch itself. Exactly one squashed slot.
- PCSrc_D together with Stall_F/Stall_D: the stall wins, nothing redirects, and the branch is re-evaluated next cycle.

## Test plan
- Reset with RESET_PC = 0x0040_0000, hold rst 2 cycles, release -> PC_F = 0x0040_0000, then 0x0040_0004 and 0x0040_0008 on successive edges; Valid_E = 0 until the first real load.
- Sequential fetch with Instr_F = 0x2008_0005 at PC 0x0 -> next cycle Instr_D = 0x2008_0005, PC_Plus4_D = 0x4; one cycle later Valid_E = 1 and Ctrl_E = Ctrl_D as sampled.
- Load-use stall: Stall_F = Stall_D = Flush_E = 1 for 1 cycle with PC_F = 0x10 -> PC_F stays 0x10, Instr_D unchanged, Ctrl_E = 0, Valid_E = 0, Stall_Cnt = 1, Flush_Cnt = 1.
- Taken branch: PCSrc_D = 1, PC_Branch_D = 0x80 -> PC_F = 0x80, Instr_D = 0, PC_Plus4_D = 0, Flush_Cnt += 1. Repeat with Stall_D = 1 -> PC and IF/ID unchanged, Flush_Cnt unchanged.
- Saturation with CNT_W = 4: hold Stall_D = 1 for 20 cycles -> Stall_Cnt reaches 15 and stays 15.
- Wrap-around: PC_F = 0xFFFF_FFFC with no stall -> next PC_F = 0x0000_0000 and PC_Plus4_D = 0x0000_0000. Then assert rst during an active stall -> all outputs return to their reset values at the next edge.
